// File: rtl/kt_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kt_uart_pkg
//  Description : Shared types and default constants for the remote command
//                link (serializer timing, command word, assembly states).
//  Revision    : 1.0  initial release
// ============================================================================
package kt_uart_pkg;

  // Clock cycles per serial bit (100 MHz / 19200 baud)
  localparam logic [15:0] BAUD_DIV_DEFAULT = 16'd5208;

  // Max clock cycles allowed between the high byte and the low byte
  localparam logic [19:0] FRAME_TO_DEFAULT = 20'd1_000_000;

  // Byte-pair assembly states: waiting for high byte / waiting for low byte
  typedef enum logic [0:0] {
    HI = 1'b0,
    LO = 1'b1
  } asm_state_t;

  // Assembled command word {hi_byte, lo_byte}
  typedef logic [15:0] cmd_t;

endpackage
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
//  Module      : uart_xcvr
//  Description : 8N1 serial receiver and transmitter. The receiver
//                synchronizes RX, samples each bit at its midpoint and
//                pulses rx_rdy for one cycle per good byte. The transmitter
//                shifts out {stop, data, start} LSB first from a registered
//                output. Both directions run independently.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_xcvr
  import kt_uart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int             CW        = $clog2(int'(BAUD_DIV) + 1);
  localparam logic [CW-1:0]  BIT_LOAD  = CW'(BAUD_DIV);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(BAUD_DIV / 16'd2);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_s3;
  logic          rx_active;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_idx;
  logic [7:0]    rx_shift;

  logic [8:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_idx;

  // Last cycle of the stop bit; lets the wrapper flag completion on the same
  // edge that drops tx_busy.
  assign tx_done = tx_busy && (tx_cnt == CNT_ONE) && (tx_idx == 4'd9);

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Receiver: half-bit delay to the start midpoint, then one sample per bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b0;
    end else begin
      rx_rdy <= 1'b0;
      if (!rx_active) begin
        if (rx_s3 && !rx_s2) begin
          rx_active <= 1'b1;
          rx_cnt    <= HALF_LOAD;
          rx_idx    <= 4'd0;
        end
      end else if (rx_cnt != CNT_ONE) begin
        rx_cnt <= rx_cnt - CNT_ONE;
      end else begin
        rx_cnt <= BIT_LOAD;
        rx_idx <= rx_idx + 4'd1;
        if (rx_idx == 4'd0) begin
          // Line already back high at the start midpoint: treat as a glitch
          if (rx_s2) begin
            rx_active <= 1'b0;
          end
        end else if (rx_idx == 4'd9) begin
          // Stop bit: a low stop is a framing error and the byte is dropped
          rx_active <= 1'b0;
          if (rx_s2) begin
            rx_data <= rx_shift;
            rx_rdy  <= 1'b1;
          end
        end else begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
        end
      end
    end
  end

  // Transmitter: start bit driven on launch, then data and stop from tx_shift
  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
    end else if (!tx_busy) begin
      tx <= 1'b1;
      if (tx_start) begin
        tx_shift <= {1'b1, tx_data};
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
        tx_cnt   <= BIT_LOAD;
        tx_idx   <= 4'd0;
      end
    end else if (tx_cnt != CNT_ONE) begin
      tx_cnt <= tx_cnt - CNT_ONE;
    end else if (tx_idx == 4'd9) begin
      tx_busy <= 1'b0;
      tx      <= 1'b1;
    end else begin
      tx       <= tx_shift[0];
      tx_shift <= {1'b1, tx_shift[8:1]};
      tx_idx   <= tx_idx + 4'd1;
      tx_cnt   <= BIT_LOAD;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_wrapper
//  Description : Command-link endpoint. Pairs received bytes (high first)
//                into 16-bit commands with a ready/ack handshake, drops a
//                stale high byte after a timeout, and sends response bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_wrapper
  import kt_uart_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter logic [19:0] FRAME_TO = FRAME_TO_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  output cmd_t       cmd,
  output logic       cmd_rdy,
  input  logic       clr_cmd_rdy,
  input  logic [7:0] resp,
  input  logic       send_resp,
  output logic       resp_sent,
  output logic       tx_busy
);

  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        tx_done;

  asm_state_t  state;
  logic [7:0]  hi_byte;
  logic [19:0] to_cnt;

  uart_xcvr #(
    .BAUD_DIV (BAUD_DIV)
  ) u_xcvr (
    .clk      (clk),
    .rst      (rst),
    .rx       (RX),
    .tx       (TX),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .tx_start (send_resp),
    .tx_data  (resp),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // Byte-pair assembly with inter-byte timeout; completion beats a same-cycle ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HI;
      hi_byte <= '0;
      to_cnt  <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      case (state)
        HI: begin
          if (rx_rdy) begin
            hi_byte <= rx_data;
            to_cnt  <= '0;
            state   <= LO;
          end
        end
        LO: begin
          if (rx_rdy) begin
            cmd     <= {hi_byte, rx_data};
            cmd_rdy <= 1'b1;
            state   <= HI;
          end else if (to_cnt == FRAME_TO - 20'd1) begin
            hi_byte <= '0;
            state   <= HI;
          end else begin
            to_cnt <= to_cnt + 20'd1;
          end
        end
        default: state <= HI;
      endcase
    end
  end

  // Response status: cleared when a byte is accepted, set when its stop bit ends
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_sent <= 1'b0;
    end else if (send_resp && !tx_busy) begin
      resp_sent <= 1'b0;
    end else if (tx_done) begin
      resp_sent <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_wrapper
//  Description : Directed, table-driven bench for uart_cmd_wrapper with
//                BAUD_DIV=16 and FRAME_TO=2000. Stimulus changes and output
//                samples both happen on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_wrapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  int tests = 0;
  int fails = 0;
  int rise  = -1;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[5];

  uart_cmd_wrapper #(
    .BAUD_DIV (16'd16),
    .FRAME_TO (20'd2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame on RX (16 cycles per bit). Records in 'rise' the
  // iteration at which cmd_rdy was first seen rising. clr_at pulses
  // clr_cmd_rdy during that iteration (-1 for none).
  task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at);
    logic [9:0] fr;
    logic       prev;
    fr   = {stop, b, 1'b0};
    prev = cmd_rdy;
    rise = -1;
    for (int i = 0; i < 160; i++) begin
      RX          = fr[i/16];
      clr_cmd_rdy = (i == clr_at);
      @(negedge clk);
      if (cmd_rdy && !prev && rise < 0) rise = i;
      prev = cmd_rdy;
    end
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    logic [9:0] txf;

    vecs[0] = '{8'h20, 8'h00, 16'h2000};
    vecs[1] = '{8'hA5, 8'h5A, 16'hA55A};
    vecs[2] = '{8'hFF, 8'hFF, 16'hFFFF};
    vecs[3] = '{8'h00, 8'h01, 16'h0001};
    vecs[4] = '{8'h80, 8'h7E, 16'h807E};

    // ---- 1: reset state, then idle line for 500 cycles
    tick(3);
    chk("rst_tx", TX, 1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_resp_sent", resp_sent, 0);
    chk("rst_tx_busy", tx_busy, 0);
    rst = 1'b0;
    for (int c = 0; c < 500; c++) begin
      tick(1);
      chk("idle_tx", TX, 1);
      chk("idle_cmd_rdy", cmd_rdy, 0);
      chk("idle_resp_sent", resp_sent, 0);
    end

    // ---- 2: table of byte pairs, latency and ack
    for (int v = 0; v < 5; v++) begin
      send_byte(vecs[v].hi, 1'b1, -1);
      chk("hi_no_rdy", cmd_rdy, 0);
      send_byte(vecs[v].lo, 1'b1, -1);
      chk("vec_cmd", cmd, vecs[v].exp);
      chk("vec_cmd_rdy", cmd_rdy, 1);
      chk("vec_latency", rise, 155);
      ack();
      chk("vec_ack", cmd_rdy, 0);
      chk("vec_cmd_hold", cmd, vecs[v].exp);
      tick(5);
    end

    // ---- 3: response 0xA5, second launch mid-frame ignored
    resp      = 8'hA5;
    txf       = {1'b1, 8'hA5, 1'b0};
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    for (int k = 1; k <= 160; k++) begin
      if ((k - 1) % 16 == 8) chk("tx_bit", TX, txf[(k-1)/16]);
      if (k == 1)   chk("tx_busy_on", tx_busy, 1);
      if (k == 80) begin
        send_resp = 1'b1;
        resp      = 8'h00;
      end
      if (k == 81)  send_resp = 1'b0;
      if (k == 160) begin
        chk("tx_busy_last", tx_busy, 1);
        chk("resp_sent_early", resp_sent, 0);
      end
      tick(1);
    end
    chk("resp_sent", resp_sent, 1);
    chk("tx_busy_off", tx_busy, 0);
    chk("tx_idle", TX, 1);
    tick(40);
    chk("tx_idle_after", TX, 1);

    // ---- 4: lone high byte times out and is dropped
    send_byte(8'h34, 1'b1, -1);
    tick(2000);
    chk("to_no_rdy", cmd_rdy, 0);
    send_byte(8'h12, 1'b1, -1);
    send_byte(8'h56, 1'b1, -1);
    chk("to_cmd", cmd, 16'h1256);
    chk("to_cmd_rdy", cmd_rdy, 1);
    ack();

    // ---- framing error: byte with low stop bit is discarded
    send_byte(8'h77, 1'b0, -1);
    tick(20);
    send_byte(8'h9A, 1'b1, -1);
    send_byte(8'hBC, 1'b1, -1);
    chk("frm_cmd", cmd, 16'h9ABC);
    chk("frm_cmd_rdy", cmd_rdy, 1);
    ack();

    // ---- 5: overrun and ack colliding with completion
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h11, 1'b1, -1);
    chk("ovr_first", cmd, 16'h1111);
    send_byte(8'h22, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    chk("ovr_cmd", cmd, 16'h2222);
    chk("ovr_cmd_rdy", cmd_rdy, 1);
    send_byte(8'h33, 1'b1, -1);
    send_byte(8'h33, 1'b1, 155);
    chk("coll_cmd", cmd, 16'h3333);
    chk("coll_cmd_rdy", cmd_rdy, 1);

    // ---- 6a: reset while a response is being shifted out
    resp      = 8'h3C;
    send_resp = 1'b1;
    tick(1);
    send_resp = 1'b0;
    chk("tx2_resp_clr", resp_sent, 0);
    chk("tx2_busy", tx_busy, 1);
    chk("tx2_start", TX, 0);
    tick(50);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_tx", TX, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_cmd", cmd, 16'h0000);
    chk("mid_rst_cmd_rdy", cmd_rdy, 0);
    chk("mid_rst_resp_sent", resp_sent, 0);
    tick(5);

    // ---- 6b: short low glitch yields no byte
    RX = 1'b0;
    tick(8);
    RX = 1'b1;
    tick(200);
    chk("glitch_no_rdy", cmd_rdy, 0);
    send_byte(8'hAB, 1'b1, -1);
    send_byte(8'hCD, 1'b1, -1);
    chk("post_cmd", cmd, 16'hABCD);
    chk("post_cmd_rdy", cmd_rdy, 1);
    chk("post_tx_idle", TX, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
